// File: rtl/anneal_sequencer_if.sv
// Job, datapath and result signals of the anneal sequencer, bundled as one interface.
// The sequencer connects through the slave modport; the job source and datapath use master.
interface anneal_sequencer_if #(
  parameter int STEPS_W = 10
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_mode;
  logic               req_update_mode;
  logic [3:0]         req_a;
  logic [3:0]         req_b;
  logic [3:0]         req_sum;
  logic [3:0]         req_log_tau;
  logic [3:0]         req_I_min;
  logic [3:0]         req_I_max;
  logic [STEPS_W-1:0] req_steps;
  logic               abort;

  logic               dp_reset;
  logic [1:0]         dp_mode;
  logic               dp_update_mode;
  logic [3:0]         dp_a;
  logic [3:0]         dp_b;
  logic [3:0]         dp_sum;
  logic [3:0]         dp_log_tau;
  logic [3:0]         dp_I_min;
  logic [3:0]         dp_I_max;
  logic [3:0]         dp_a_out;
  logic [3:0]         dp_b_out;
  logic [3:0]         dp_sum_out;
  logic               dp_overflow;

  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_a;
  logic [3:0]         res_b;
  logic [3:0]         res_sum;
  logic               res_ovf;
  logic               res_consistent;
  logic               busy;

  modport master (
    output req_valid, req_mode, req_update_mode, req_a, req_b, req_sum,
           req_log_tau, req_I_min, req_I_max, req_steps, abort,
           dp_a_out, dp_b_out, dp_sum_out, dp_overflow, res_ready,
    input  req_ready, dp_reset, dp_mode, dp_update_mode, dp_a, dp_b, dp_sum,
           dp_log_tau, dp_I_min, dp_I_max, res_valid, res_a, res_b, res_sum,
           res_ovf, res_consistent, busy
  );

  modport slave (
    input  req_valid, req_mode, req_update_mode, req_a, req_b, req_sum,
           req_log_tau, req_I_min, req_I_max, req_steps, abort,
           dp_a_out, dp_b_out, dp_sum_out, dp_overflow, res_ready,
    output req_ready, dp_reset, dp_mode, dp_update_mode, dp_a, dp_b, dp_sum,
           dp_log_tau, dp_I_min, dp_I_max, res_valid, res_a, res_b, res_sum,
           res_ovf, res_consistent, busy
  );
endinterface

// File: rtl/anneal_sequencer.sv
// Runs one annealing job: datapath reset, burn-in, N sample cycles of per-bit
// counting, then presents the strict-majority value of every datapath output bit.
module anneal_sequencer #(
  parameter int STEPS_W = 10,
  parameter int SETTLE  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  anneal_sequencer_if.slave  bus
);

  localparam int TW = (STEPS_W > 8) ? STEPS_W : 8;
  localparam int NB = 13;
  localparam logic [TW-1:0] DPRST_LAST  = TW'(1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DPRST,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         mode_q;
  logic               upd_q;
  logic [3:0]         a_q, b_q, sum_q, tau_q, imin_q, imax_q;
  logic [STEPS_W-1:0] steps_q;
  logic [NB-1:0]      res_q;
  logic               cons_q;
  logic [NB-1:0]      maj;
  logic [NB-1:0]      dp_bits;
  logic               accept;
  logic               count_en;
  logic               clear_cnt;
  logic               maj_cons;

  // Bit order {ovf, sum[3:0], b[3:0], a[3:0]} is shared by counters and results.
  assign dp_bits   = {bus.dp_overflow, bus.dp_sum_out, bus.dp_b_out, bus.dp_a_out};
  assign accept    = (state_q == S_IDLE) && bus.req_valid;
  assign clear_cnt = (state_q == S_IDLE) || bus.abort;
  // The SAMPLE cycle with timer_q == steps_q only tallies: counters are final there.
  assign count_en  = (state_q == S_SAMPLE) && (timer_q < TW'(steps_q));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = S_DPRST;
      end
      S_DPRST: begin
        if (bus.abort)                  state_d = S_IDLE;
        else if (timer_q == DPRST_LAST) state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (bus.abort)                   state_d = S_IDLE;
        else if (timer_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.abort)                     state_d = S_IDLE;
        else if (timer_q == TW'(steps_q))  state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.abort || bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || state_q == S_IDLE) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      upd_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      tau_q   <= '0;
      imin_q  <= '0;
      imax_q  <= '0;
      steps_q <= '0;
    end else if (accept) begin
      mode_q  <= (bus.req_mode == 2'd3) ? 2'd0 : bus.req_mode;
      upd_q   <= bus.req_update_mode;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      sum_q   <= bus.req_sum;
      tau_q   <= bus.req_log_tau;
      imin_q  <= bus.req_I_min;
      imax_q  <= bus.req_I_max;
      steps_q <= (bus.req_steps == '0) ? STEPS_W'(1) : bus.req_steps;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_vote
      logic [STEPS_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  cnt_q <= '0;
        else if (clear_cnt)                          cnt_q <= '0;
        else if (count_en && dp_bits[gi] && cnt_q != '1) cnt_q <= cnt_q + STEPS_W'(1);
      end
      // Strict majority: a tie (2*count == steps) votes 0.
      assign maj[gi] = {cnt_q, 1'b0} > {1'b0, steps_q};
    end
  endgenerate

  assign maj_cons = ({maj[12], maj[11:8]} == ({1'b0, maj[3:0]} + {1'b0, maj[7:4]}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      cons_q <= 1'b0;
    end else if (state_q == S_SAMPLE && state_d == S_DONE) begin
      res_q  <= maj;
      cons_q <= maj_cons;
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.dp_reset       = (state_q == S_IDLE) || (state_q == S_DPRST);
  assign bus.dp_mode        = mode_q;
  assign bus.dp_update_mode = upd_q;
  assign bus.dp_a           = a_q;
  assign bus.dp_b           = b_q;
  assign bus.dp_sum         = sum_q;
  assign bus.dp_log_tau     = tau_q;
  assign bus.dp_I_min       = imin_q;
  assign bus.dp_I_max       = imax_q;
  assign bus.res_valid      = (state_q == S_DONE);
  assign bus.res_a          = res_q[3:0];
  assign bus.res_b          = res_q[7:4];
  assign bus.res_sum        = res_q[11:8];
  assign bus.res_ovf        = res_q[12];
  assign bus.res_consistent = cons_q;

endmodule

// File: tb/tb_anneal_sequencer.sv
// Directed bench for anneal_sequencer: a table of jobs with a constant-output
// datapath stub, plus hand-written hold, abort and mid-job reset sequences.
module tb_anneal_sequencer;

  localparam int STEPS_W = 10;
  localparam int SETTLE  = 16;
  localparam int BUDGET  = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  anneal_sequencer_if #(.STEPS_W(STEPS_W)) bus ();

  anneal_sequencer #(.STEPS_W(STEPS_W), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]         mode;
    logic [3:0]         a, b, sum;
    logic [STEPS_W-1:0] steps;
    logic [3:0]         sa, sb, ss;
    logic               so;
    bit                 junk;    // drive all-ones before the first sample cycle
    int                 pulses;  // >=0: sum_out[0]=1 only on the first 'pulses' samples
    logic [3:0]         ea, eb, es;
    logic               eo, ec;
    logic [1:0]         emode;
    int                 lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_stub(input vec_t v, input int j);
    int k;
    logic [3:0] s;
    k = j - (2 + SETTLE);
    if (v.junk && k < 0) begin
      bus.dp_a_out = 4'hF; bus.dp_b_out = 4'hF; bus.dp_sum_out = 4'hF; bus.dp_overflow = 1'b1;
    end else begin
      s = v.ss;
      if (v.pulses >= 0) s[0] = (k >= 0 && k < v.pulses);
      bus.dp_a_out = v.sa; bus.dp_b_out = v.sb; bus.dp_sum_out = s; bus.dp_overflow = v.so;
    end
  endtask

  task automatic start_job(input vec_t v);
    bus.req_mode = v.mode; bus.req_update_mode = 1'b1;
    bus.req_a = v.a; bus.req_b = v.b; bus.req_sum = v.sum;
    bus.req_log_tau = 4'd5; bus.req_I_min = 4'd1; bus.req_I_max = 4'd9;
    bus.req_steps = v.steps; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drive_stub(v, 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int hold);
    int j;
    start_job(v);
    j = 0;
    check({tag, ".dp_reset_c0"}, bus.dp_reset, 1);
    check({tag, ".req_ready_busy"}, bus.req_ready, 0);
    while (!bus.res_valid && j < BUDGET) begin
      @(posedge clk); #1;
      j++;
      drive_stub(v, j);
      if (j == 1) check({tag, ".dp_reset_c1"}, bus.dp_reset, 1);
      if (j == 2) check({tag, ".dp_reset_c2"}, bus.dp_reset, 0);
    end
    $display("job %s: res_valid after %0d cycles a=%0h b=%0h sum=%0h ovf=%0b cons=%0b",
             tag, j, bus.res_a, bus.res_b, bus.res_sum, bus.res_ovf, bus.res_consistent);
    check({tag, ".latency"}, j, v.lat);
    check({tag, ".res_a"}, bus.res_a, v.ea);
    check({tag, ".res_b"}, bus.res_b, v.eb);
    check({tag, ".res_sum"}, bus.res_sum, v.es);
    check({tag, ".res_ovf"}, bus.res_ovf, v.eo);
    check({tag, ".res_consistent"}, bus.res_consistent, v.ec);
    check({tag, ".dp_mode"}, bus.dp_mode, v.emode);
    check({tag, ".dp_a"}, bus.dp_a, v.a);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, bus.res_valid, 1);
      check({tag, ".hold_res_a"}, bus.res_a, v.ea);
      check({tag, ".hold_res_sum"}, bus.res_sum, v.es);
      check({tag, ".hold_req_ready"}, bus.req_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, ".idle_req_ready"}, bus.req_ready, 1);
    check({tag, ".idle_res_valid"}, bus.res_valid, 0);
  endtask

  vec_t vecs[7];
  vec_t vhold, vlong, vnext;

  initial begin
    int j;
    bit seen;
    vecs[0] = '{2'd0, 4'd1, 4'd7, 4'd8, 10'd100, 4'd1, 4'd7, 4'd8, 1'b0, 1'b0, -1,
                4'd1, 4'd7, 4'd8, 1'b0, 1'b1, 2'd0, 119};
    vecs[1] = '{2'd0, 4'd0, 4'd0, 4'd0, 10'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, -1,
                4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 20};
    vecs[2] = '{2'd0, 4'd0, 4'd0, 4'd0, 10'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2,
                4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 23};
    vecs[3] = '{2'd0, 4'd0, 4'd0, 4'd0, 10'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3,
                4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 2'd0, 23};
    vecs[4] = '{2'd3, 4'd5, 4'd6, 4'd9, 10'd3, 4'hF, 4'd1, 4'd0, 1'b1, 1'b0, -1,
                4'hF, 4'd1, 4'd0, 1'b1, 1'b1, 2'd0, 22};
    vecs[5] = '{2'd1, 4'd2, 4'd2, 4'd4, 10'd1, 4'd3, 4'd3, 4'd5, 1'b0, 1'b0, -1,
                4'd3, 4'd3, 4'd5, 1'b0, 1'b0, 2'd1, 20};
    vecs[6] = '{2'd2, 4'd3, 4'd0, 4'd12, 10'd7, 4'd3, 4'd9, 4'd12, 1'b0, 1'b0, -1,
                4'd3, 4'd9, 4'd12, 1'b0, 1'b1, 2'd2, 26};
    vhold   = '{2'd0, 4'd2, 4'd3, 4'd5, 10'd2, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, -1,
                4'd2, 4'd3, 4'd5, 1'b0, 1'b1, 2'd0, 21};
    vlong   = vecs[0];
    vnext   = '{2'd2, 4'd3, 4'd0, 4'd12, 10'd5, 4'd0, 4'd9, 4'd0, 1'b0, 1'b0, -1,
                4'd0, 4'd9, 4'd0, 1'b0, 1'b0, 2'd2, 24};

    bus.req_valid = 1'b0; bus.req_mode = '0; bus.req_update_mode = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_sum = '0;
    bus.req_log_tau = '0; bus.req_I_min = '0; bus.req_I_max = '0;
    bus.req_steps = '0; bus.abort = 1'b0; bus.res_ready = 1'b0;
    bus.dp_a_out = '0; bus.dp_b_out = '0; bus.dp_sum_out = '0; bus.dp_overflow = 1'b0;

    #1;
    check("rst.req_ready", bus.req_ready, 1);
    check("rst.busy", bus.busy, 0);
    check("rst.dp_reset", bus.dp_reset, 1);
    check("rst.res_valid", bus.res_valid, 0);
    check("rst.res_consistent", bus.res_consistent, 0);
    check("rst.dp_mode", bus.dp_mode, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    run_vec("hold", vhold, 10);

    // Abort during sample 50 of 100, then a fresh job must see cleared counters.
    start_job(vlong);
    j = 0;
    seen = 0;
    while (j < 2 + SETTLE + 49) begin
      @(posedge clk); #1;
      j++;
      drive_stub(vlong, j);
      if (bus.res_valid) seen = 1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    $display("abort: busy=%0b req_ready=%0b res_valid=%0b", bus.busy, bus.req_ready, bus.res_valid);
    check("abort.busy", bus.busy, 0);
    check("abort.req_ready", bus.req_ready, 1);
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1;
    end
    check("abort.no_result", seen, 0);
    run_vec("after_abort", vnext, 0);

    // Asynchronous reset in the middle of SAMPLE.
    start_job(vlong);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      drive_stub(vlong, c);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0b req_ready=%0b dp_reset=%0b res_b=%0h",
             bus.busy, bus.req_ready, bus.dp_reset, bus.res_b);
    check("arst.busy", bus.busy, 0);
    check("arst.req_ready", bus.req_ready, 1);
    check("arst.dp_reset", bus.dp_reset, 1);
    check("arst.dp_a", bus.dp_a, 0);
    check("arst.res_b", bus.res_b, 0);
    check("arst.res_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.rel_req_ready", bus.req_ready, 1);
    check("arst.rel_dp_reset", bus.dp_reset, 1);
    seen = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.busy) seen = 1;
    end
    check("arst.no_result", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anneal_sequencer.md
ANNEAL_SEQUENCER -- requirements
Module: anneal_sequencer

Interface
REQ-001 Parameter STEPS_W, default 10, sets the width of the sample-count field and of each bit counter.
REQ-002 Parameter SETTLE, default 16, sets the number of burn-in cycles discarded before sampling (range 0..255).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  job request handshake.
REQ-006 req_mode  in  2  0=forward a+b, 1=inverse sum, 2=subtract b=s-a; 3 is treated as 0.
REQ-007 req_update_mode  in  1  passed through to the datapath.
REQ-008 req_a, req_b, req_sum  in  4 each  operand clamps.
REQ-009 req_log_tau, req_I_min, req_I_max  in  4 each  annealer settings.
REQ-010 req_steps  in  STEPS_W  number of sample cycles; 0 is treated as 1.
REQ-011 abort  in  1  cancels any active job.
REQ-012 dp_reset  out  1  active-high datapath/annealer reset.
REQ-013 dp_mode (2), dp_update_mode (1), dp_a, dp_b, dp_sum, dp_log_tau, dp_I_min, dp_I_max (4 each)  out  latched job fields.
REQ-014 dp_a_out, dp_b_out, dp_sum_out (4 each), dp_overflow (1)  in  datapath p-bit outputs.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-016 res_a, res_b, res_sum (4 each), res_ovf (1), res_consistent (1)  out  majority-vote result.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, DPRST, SETTLE, SAMPLE and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a job SHALL be accepted on a cycle where req_valid and req_ready are both high, and all req_* fields latched that cycle.
REQ-020 On accept, the FSM SHALL go to DPRST, hold dp_reset=1 for exactly 2 cycles, then go to SETTLE, or to SAMPLE directly if SETTLE=0.
REQ-021 SETTLE SHALL last exactly SETTLE cycles with dp_reset=0 and no counting.
REQ-022 SAMPLE SHALL last exactly max(req_steps,1) cycles; on each SAMPLE cycle, for each of the 13 dp output bits, that bit's counter SHALL increment when the bit is 1.
REQ-023 Counters SHALL be STEPS_W bits wide, clear on accept, and never wrap (count ≤ steps).
REQ-024 Each result bit SHALL be 1 iff 2*count > steps (strict majority; a tie gives 0), with results registered on the SAMPLE→DONE transition.
REQ-025 res_valid SHALL be 1 in DONE, asserted exactly 2+SETTLE+N+1 cycles after the accept edge (N = effective steps).
REQ-026 res_* SHALL be held stable while res_valid=1 and res_ready=0; res_valid&res_ready SHALL return the FSM to IDLE on the next cycle.
REQ-027 res_consistent SHALL be 1 iff {res_ovf,res_sum} == res_a + res_b (5-bit).
REQ-028 dp_mode, dp_update_mode, dp_a, dp_b, dp_sum and the annealer outputs SHALL stay constant from accept until return to IDLE.
REQ-029 In IDLE, dp_reset SHALL be 1.
REQ-030 abort=1 in any non-IDLE state SHALL send the FSM to IDLE on the next edge, clear the counters, and suppress res_valid.
REQ-031 abort together with res_ready in DONE SHALL go to IDLE, with the result treated as dropped.
REQ-032 abort in IDLE SHALL be ignored; req_valid is not accepted while busy=1.

Reset
REQ-033 While reset=0, the state SHALL be IDLE and the counters cleared.
REQ-034 While reset=0, res_* SHALL be 0, res_valid=0, busy=0, dp_reset=1, all other dp_* outputs 0, and req_ready=1, with handshakes ignored until reset=1.
REQ-035 Reset asserted mid-job SHALL take effect immediately (asynchronously), and no result SHALL be produced for that job.

Verification
REQ-036 Stub drives a_out=1, b_out=7, sum_out=8, ovf=0; job mode 0, steps=100, SETTLE=16 -> res_valid exactly 119 cycles after accept; res=1,7,8,0; res_consistent=1.
REQ-037 steps=4; stub drives sum_out[0]=1 on exactly 2 sample cycles -> res_sum[0]=0; repeat with 3 cycles -> res_sum[0]=1.
REQ-038 Stub drives 4'hF on all outputs during SETTLE and 0 during SAMPLE; steps=0 -> exactly one sample is counted; res all 0.
REQ-039 Hold res_ready=0 for 10 cycles in DONE -> res_valid stays 1, res_* unchanged, req_ready=0; res_ready=1 -> IDLE next cycle.
REQ-040 abort at sample 50 of 100 -> IDLE next cycle, res_valid never 1; the next job (mode 2, a=3, sum=12, stub b_out=9) -> res_b=9.
REQ-041 reset=0 mid-SAMPLE -> outputs reach reset values without a clock edge; after release, req_ready=1 and dp_reset=1.
